// File: rtl/bpm_pkg.sv
// Shared constants, FSM state encoding and helpers for the autocorrelation
// tempo estimator and its divider.
package bpm_pkg;

  // Tempo search range and correlation window (frames at 46.875 frames/s)
  localparam int LAG_MIN = 14;
  localparam int LAG_MAX = 47;
  localparam int WIN     = 128;
  localparam int BPM_NUM = 2813;

  // Default datapath widths
  localparam int SAMP_W  = 16;
  localparam int ACC_W   = 40;

  // Divider operand widths: numerator covers BPM_NUM + LAG_MAX/2, divisor a lag
  localparam int DIV_NUM_W = 12;
  localparam int DIV_DEN_W = 6;

  typedef logic [SAMP_W-1:0] samp_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAG_INIT,
    S_MAC,
    S_LAG_END,
    S_DIV,
    S_DONE
  } bpm_state_t;

  // Rounded-division numerator: (num + lag/2) so that num/lag rounds to nearest
  function automatic logic [DIV_NUM_W-1:0] round_numer(input int num,
                                                       input logic [DIV_DEN_W-1:0] lag);
    return DIV_NUM_W'(num) + DIV_NUM_W'(lag >> 1);
  endfunction

endpackage

// File: rtl/bpm_divider.sv
// Sequential restoring divider producing one quotient bit per cycle.
// A zero divisor naturally yields an all-ones quotient.
module bpm_divider
  import bpm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_NUM_W-1:0] numer,
  input  logic [DIV_DEN_W-1:0] denom,
  output logic                 done,
  output logic [DIV_NUM_W-1:0] quot
);

  localparam int CNT_W = $clog2(DIV_NUM_W);

  logic                 run_reg;
  logic                 done_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DIV_DEN_W-1:0] rem_reg;
  logic [DIV_DEN_W-1:0] den_reg;
  logic [DIV_NUM_W-1:0] quo_reg;

  logic [DIV_DEN_W:0]   rem_shift;
  logic [DIV_DEN_W:0]   rem_diff;
  logic                 q_bit;

  // Trial subtraction of the divisor from the partial remainder
  always_comb begin
    rem_shift = {rem_reg, quo_reg[DIV_NUM_W-1]};
    rem_diff  = rem_shift - {1'b0, den_reg};
    q_bit     = (rem_shift >= {1'b0, den_reg});
  end

  // Iteration control: load on start, shift one bit per cycle, pulse done at the end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
      rem_reg  <= '0;
      den_reg  <= '0;
      quo_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (run_reg) begin
        rem_reg <= q_bit ? rem_diff[DIV_DEN_W-1:0] : rem_shift[DIV_DEN_W-1:0];
        quo_reg <= {quo_reg[DIV_NUM_W-2:0], q_bit};
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(DIV_NUM_W-1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end else if (start) begin
        quo_reg <= numer;
        den_reg <= denom;
        rem_reg <= '0;
        cnt_reg <= '0;
        run_reg <= 1'b1;
      end
    end
  end

  assign done = done_reg;
  assign quot = quo_reg;

endmodule

// File: rtl/flux_autocorr_bpm.sv
// Tempo estimator: buffers per-frame flux, autocorrelates the newest window
// over the tempo lag range and converts the winning lag to an integer BPM.
module flux_autocorr_bpm #(
  parameter int FLUX_W     = 43,
  parameter int SAMP_W     = 16,
  parameter int FLUX_SHIFT = 20,
  parameter int DEPTH      = 256,
  parameter int WIN        = bpm_pkg::WIN,
  parameter int LAG_MIN    = bpm_pkg::LAG_MIN,
  parameter int LAG_MAX    = bpm_pkg::LAG_MAX,
  parameter int ACC_W      = 40,
  parameter int BPM_NUM    = bpm_pkg::BPM_NUM,
  parameter int BPM_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flux_valid,
  input  logic [FLUX_W-1:0] flux_value,
  output logic [BPM_W-1:0]  bpm,
  output logic              bpm_valid,
  output logic [5:0]        best_lag,
  output logic              busy
);

  import bpm_pkg::bpm_state_t;
  import bpm_pkg::S_IDLE;
  import bpm_pkg::S_LAG_INIT;
  import bpm_pkg::S_MAC;
  import bpm_pkg::S_LAG_END;
  import bpm_pkg::S_DIV;
  import bpm_pkg::S_DONE;
  import bpm_pkg::round_numer;
  import bpm_pkg::DIV_NUM_W;
  import bpm_pkg::DIV_DEN_W;

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int IDX_W    = $clog2(WIN + 1);
  localparam int FILL_MAX = WIN + LAG_MAX;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam int LAG_W    = 6;
  localparam int PROD_W   = 2 * SAMP_W;

  // Frame history; read port is registered so it maps onto block RAM
  logic [SAMP_W-1:0] mem [DEPTH];
  logic [SAMP_W-1:0] rd_data_reg;
  logic [ADDR_W-1:0] rd_addr;

  bpm_state_t        state_reg,    state_next;
  logic [ADDR_W-1:0] wr_ptr_reg,   wr_ptr_next;
  logic [FILL_W-1:0] fill_reg,     fill_next;
  logic              pending_reg,  pending_next;
  logic [ADDR_W-1:0] base_reg,     base_next;
  logic [LAG_W-1:0]  lag_reg,      lag_next;
  logic [IDX_W-1:0]  idx_reg,      idx_next;
  logic              phase_reg,    phase_next;
  logic              mac_pend_reg, mac_pend_next;
  logic [ACC_W-1:0]  acc_reg,      acc_next;
  logic [ACC_W-1:0]  best_acc_reg, best_acc_next;
  logic [LAG_W-1:0]  cand_lag_reg, cand_lag_next;
  logic [SAMP_W-1:0] x_a_reg,      x_a_next;
  logic [BPM_W-1:0]  bpm_reg,      bpm_next;
  logic              bpm_valid_reg, bpm_valid_next;
  logic [LAG_W-1:0]  best_lag_reg, best_lag_next;

  logic [FLUX_W-1:0]    flux_shifted;
  logic [SAMP_W-1:0]    sample;
  logic [FILL_W-1:0]    fill_inc;
  logic [PROD_W-1:0]    prod;
  logic [LAG_W-1:0]     lag_sel;
  logic                 div_start;
  logic [DIV_NUM_W-1:0] div_numer;
  logic [DIV_DEN_W-1:0] div_denom;
  logic                 div_done;
  logic [DIV_NUM_W-1:0] div_quot;
  logic [BPM_W-1:0]     bpm_clip;

  // Scale incoming flux and saturate it into the sample width
  always_comb begin
    flux_shifted = flux_value >> FLUX_SHIFT;
    sample       = (|flux_shifted[FLUX_W-1:SAMP_W]) ? '1 : flux_shifted[SAMP_W-1:0];
    fill_inc     = (fill_reg == FILL_W'(FILL_MAX)) ? fill_reg : fill_reg + 1'b1;
    prod         = x_a_reg * rd_data_reg;
    bpm_clip     = (div_quot > DIV_NUM_W'((1 << BPM_W) - 1)) ? '1 : BPM_W'(div_quot);
  end

  // Ring buffer write on every frame and registered read for the correlator
  always_ff @(posedge clk) begin
    if (flux_valid) begin
      mem[wr_ptr_reg] <= sample;
    end
    rd_data_reg <= mem[rd_addr];
  end

  bpm_divider u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .numer (div_numer),
    .denom (div_denom),
    .done  (div_done),
    .quot  (div_quot)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      fill_reg      <= '0;
      pending_reg   <= 1'b0;
      base_reg      <= '0;
      lag_reg       <= '0;
      idx_reg       <= '0;
      phase_reg     <= 1'b0;
      mac_pend_reg  <= 1'b0;
      acc_reg       <= '0;
      best_acc_reg  <= '0;
      cand_lag_reg  <= '0;
      x_a_reg       <= '0;
      bpm_reg       <= '0;
      bpm_valid_reg <= 1'b0;
      best_lag_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      fill_reg      <= fill_next;
      pending_reg   <= pending_next;
      base_reg      <= base_next;
      lag_reg       <= lag_next;
      idx_reg       <= idx_next;
      phase_reg     <= phase_next;
      mac_pend_reg  <= mac_pend_next;
      acc_reg       <= acc_next;
      best_acc_reg  <= best_acc_next;
      cand_lag_reg  <= cand_lag_next;
      x_a_reg       <= x_a_next;
      bpm_reg       <= bpm_next;
      bpm_valid_reg <= bpm_valid_next;
      best_lag_reg  <= best_lag_next;
    end
  end

  // Next-state: frame ingest, lag sweep with two-cycle MAC, best-lag search, BPM conversion
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    fill_next      = fill_reg;
    pending_next   = pending_reg;
    base_next      = base_reg;
    lag_next       = lag_reg;
    idx_next       = idx_reg;
    phase_next     = phase_reg;
    mac_pend_next  = mac_pend_reg;
    acc_next       = acc_reg;
    best_acc_next  = best_acc_reg;
    cand_lag_next  = cand_lag_reg;
    x_a_next       = x_a_reg;
    bpm_next       = bpm_reg;
    bpm_valid_next = 1'b0;
    best_lag_next  = best_lag_reg;
    rd_addr        = base_reg - ADDR_W'(idx_reg);
    div_start      = 1'b0;
    lag_sel        = (acc_reg > best_acc_reg) ? lag_reg : cand_lag_reg;
    div_numer      = round_numer(BPM_NUM, lag_sel);
    div_denom      = lag_sel;

    // Frames are stored regardless of what the correlator is doing
    if (flux_valid) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
      fill_next   = fill_inc;
      if (state_reg != S_IDLE) begin
        pending_next = 1'b1;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (flux_valid && (fill_inc >= FILL_W'(FILL_MAX))) begin
          base_next     = wr_ptr_reg;
          lag_next      = LAG_W'(LAG_MIN);
          best_acc_next = '0;
          cand_lag_next = LAG_W'(LAG_MIN);
          state_next    = S_LAG_INIT;
        end
      end

      S_LAG_INIT: begin
        acc_next      = '0;
        idx_next      = '0;
        phase_next    = 1'b0;
        mac_pend_next = 1'b0;
        state_next    = S_MAC;
      end

      // Phase 0 addresses x[base-i] and folds in the previous product;
      // phase 1 addresses x[base-i-lag] while capturing x[base-i].
      S_MAC: begin
        if (!phase_reg) begin
          if (mac_pend_reg) begin
            acc_next = acc_reg + ACC_W'(prod);
          end
          mac_pend_next = 1'b0;
          if (idx_reg == IDX_W'(WIN)) begin
            state_next = S_LAG_END;
          end else begin
            phase_next = 1'b1;
          end
        end else begin
          rd_addr       = base_reg - ADDR_W'(idx_reg) - ADDR_W'(lag_reg);
          x_a_next      = rd_data_reg;
          idx_next      = idx_reg + 1'b1;
          phase_next    = 1'b0;
          mac_pend_next = 1'b1;
        end
      end

      // Strict comparison so ties keep the smaller (earlier) lag
      S_LAG_END: begin
        if (acc_reg > best_acc_reg) begin
          best_acc_next = acc_reg;
          cand_lag_next = lag_reg;
        end
        if (lag_reg == LAG_W'(LAG_MAX)) begin
          div_start  = 1'b1;
          state_next = S_DIV;
        end else begin
          lag_next   = lag_reg + 1'b1;
          state_next = S_LAG_INIT;
        end
      end

      // A silent window has no meaningful tempo, so report zero
      S_DIV: begin
        if (div_done) begin
          bpm_next       = (best_acc_reg == '0) ? '0 : bpm_clip;
          best_lag_next  = cand_lag_reg;
          bpm_valid_next = 1'b1;
          state_next     = S_DONE;
        end
      end

      // Restart immediately on the newest frame if frames arrived meanwhile
      S_DONE: begin
        if (pending_reg || flux_valid) begin
          pending_next  = 1'b0;
          base_next     = flux_valid ? wr_ptr_reg : wr_ptr_reg - 1'b1;
          lag_next      = LAG_W'(LAG_MIN);
          best_acc_next = '0;
          cand_lag_next = LAG_W'(LAG_MIN);
          state_next    = S_LAG_INIT;
        end else begin
          state_next    = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bpm       = bpm_reg;
  assign bpm_valid = bpm_valid_reg;
  assign best_lag  = best_lag_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_flux_autocorr_bpm.sv
// Self-checking bench for flux_autocorr_bpm: table of frame patterns with
// expected tempo results queued at the frame that triggers each estimate.
module tb_flux_autocorr_bpm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flux_valid = 1'b0;
  logic [42:0] flux_value = '0;
  logic [7:0]  bpm;
  logic        bpm_valid;
  logic [5:0]  best_lag;
  logic        busy;

  flux_autocorr_bpm dut (
    .clk        (clk),
    .reset      (reset),
    .flux_valid (flux_valid),
    .flux_value (flux_value),
    .bpm        (bpm),
    .bpm_valid  (bpm_valid),
    .best_lag   (best_lag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lag;
    int bpm;
  } exp_t;

  typedef struct {
    string       name;
    int          kind;     // 0: constant, 1: impulse train
    logic [42:0] amp;
    int          period;
    int          nframes;
    int          exp_lag;
    int          exp_bpm;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  localparam logic [42:0] AMP30 = 43'd1 << 30;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input int kind,
                         input logic [42:0] amp, input int period, input int nframes,
                         input int lag, input int bpm_e);
    vecs[i].name    = nm;
    vecs[i].kind    = kind;
    vecs[i].amp     = amp;
    vecs[i].period  = period;
    vecs[i].nframes = nframes;
    vecs[i].exp_lag = lag;
    vecs[i].exp_bpm = bpm_e;
  endtask

  task automatic push_exp(input int lag, input int bpm_e);
    exp_t e;
    e.lag = lag;
    e.bpm = bpm_e;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every bpm_valid must match the oldest expectation
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset && bpm_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bpm_valid: got bpm=%0d best_lag=%0d, required no pulse",
                   bpm, best_lag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("estimate @%0t: bpm=%0d best_lag=%0d (want %0d/%0d)",
                   $time, bpm, best_lag, e.bpm, e.lag);
          chk("bpm", longint'(bpm), longint'(e.bpm));
          chk("best_lag", longint'(best_lag), longint'(e.lag));
        end
      end
    end
  endtask

  task automatic send_frame(input logic [42:0] v);
    @(posedge clk);
    #1;
    flux_valid = 1'b1;
    flux_value = v;
    @(posedge clk);
    #1;
    flux_valid = 1'b0;
    flux_value = '0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    int n;
    budget = 9200 * exp_q.size();
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d estimates outstanding after %0d cycles, required 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    set_vec(0, "impulse20", 1, 43'd1 << 24, 20, 200, 20, 141);
    set_vec(1, "saturate",  0, 43'h3FF_FFFF_FFFF, 1, 176, 14, 201);
    set_vec(2, "silence",   0, 43'd1048575, 1, 175, 14, 0);
    set_vec(3, "impulse30", 1, 43'd1 << 30, 30, 175, 30, 94);
    set_vec(4, "impulse47", 1, 43'd1 << 25, 47, 175, 47, 60);

    // Reset held with random strobes: outputs stay cleared
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      flux_valid = 1'($urandom_range(0, 1));
      flux_value = 43'({$urandom(), $urandom()});
    end
    @(negedge clk);
    chk("reset_bpm", longint'(bpm), 0);
    chk("reset_bpm_valid", longint'(bpm_valid), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_best_lag", longint'(best_lag), 0);
    flux_valid = 1'b0;
    flux_value = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // One frame short of a full window: no estimate may start
    pulses = 0;
    for (int k = 0; k < 174; k++) begin
      send_frame(43'({$urandom(), $urandom()}));
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("busy_after_174", longint'(busy), 0);
    chk("pulses_after_174", longint'(pulses), 0);

    // Table of frame patterns, each from a fresh reset
    for (int v = 0; v < 5; v++) begin
      int exp_n;
      logic [42:0] fv;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      pulses = 0;
      exp_n = 0;
      $display("vector %s: %0d frames", vecs[v].name, vecs[v].nframes);
      for (int k = 0; k < vecs[v].nframes; k++) begin
        if (vecs[v].kind == 0 || (k % vecs[v].period) == 0) fv = vecs[v].amp;
        else fv = '0;
        // Frame 175 starts an estimate; frame 176 arrives while busy and queues one more
        if (k == 174 || k == 175) begin
          push_exp(vecs[v].exp_lag, vecs[v].exp_bpm);
          exp_n++;
        end
        send_frame(fv);
        if (k == 174) begin
          @(negedge clk);
          chk("busy_on_start", longint'(busy), 1);
        end
      end
      wait_drain(vecs[v].name);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("busy_after_done", longint'(busy), 0);
      chk("pulse_count", longint'(pulses), longint'(exp_n));
    end

    // Asynchronous reset in the middle of a correlation
    pulses = 0;
    send_frame(AMP30);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_mac", longint'(busy), 1);
    chk("bpm_before_reset", longint'(bpm), 60);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_busy", longint'(busy), 0);
    chk("async_bpm", longint'(bpm), 0);
    chk("async_bpm_valid", longint'(bpm_valid), 0);
    chk("async_best_lag", longint'(best_lag), 0);

    // Fill restarts from zero: 174 frames give nothing, the 175th gives an estimate
    for (int k = 0; k < 174; k++) begin
      send_frame(AMP30);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("refill_busy_174", longint'(busy), 0);
    chk("refill_pulses_174", longint'(pulses), 0);
    push_exp(14, 201);
    send_frame(AMP30);
    wait_drain("refill");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("refill_pulse_count", longint'(pulses), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
